// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: serial double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN_TO_BCD_LEADING_BLANK_EN to replace leading zero digits with 4'hF.
module bin_to_bcd_seq #(
  parameter int BIN_W = 14,
  parameter logic [15:0] SAT_VAL = 16'h9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [15:0]      bcd_out
);
  localparam int CW = $clog2(BIN_W);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [BIN_W-1:0] bin_sr;
  logic [15:0] scr, adj, nxt, fin;
  logic [CW-1:0] cnt;
  logic ovf_f, last;
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i+:4] = (scr[4*i+:4] >= 4'd5) ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
  end
  assign nxt  = (adj << 1) | 16'(bin_sr[BIN_W-1]);
  assign busy = (state == SHIFT);
  assign last = (cnt == LAST);
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
  // Blank from the thousands digit down until the first non-zero digit; units always shown.
  always_comb begin
    fin = nxt;
    if (nxt[15:12] == 4'd0) begin
      fin[15:12] = 4'hF;
      if (nxt[11:8] == 4'd0) begin
        fin[11:8] = 4'hF;
        if (nxt[7:4] == 4'd0) fin[7:4] = 4'hF;
      end
    end
  end
`else
  assign fin = nxt;
`endif
  always_comb begin
    state_n = (state == IDLE) ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr  <= '0;
      scr     <= '0;
      cnt     <= '0;
      ovf_f   <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        bin_sr <= bin_in;
        scr    <= '0;
        cnt    <= '0;
        ovf_f  <= {{(32-BIN_W){1'b0}}, bin_in} > 32'd9999;
      end else if (state == SHIFT) begin
        scr    <= nxt;
        bin_sr <= bin_sr << 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          done    <= 1'b1;
          ovf     <= ovf_f;
          bcd_out <= ovf_f ? SAT_VAL : fin;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq at BIN_W=14.
module tb_bin_to_bcd_seq;
  localparam int BW = 14;
  logic clk = 1'b0;
  logic rst, start, busy, done, ovf;
  logic [BW-1:0] bin_in;
  logic [15:0] bcd_out;
  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.BIN_W(BW), .SAT_VAL(16'h9999)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
    .busy(busy), .done(done), .ovf(ovf), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a start now, then wait for done; checks busy/held output while converting.
  task automatic convert(input string tag, input logic [BW-1:0] v, input logic [15:0] eb,
                         input logic eo, input logic [15:0] prev);
    int n;
    bit bad;
    bin_in = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin_in = '0;
    n = 0;
    bad = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || bcd_out !== prev) bad = 1;
      tick();
      n++;
    end
    chk({tag, "_busy_hold"}, 32'(bad), 32'd0);
    chk({tag, "_latency"}, n, BW);
    chk({tag, "_bcd"}, bcd_out, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_busy_done"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    bit bad;
    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("reset_idle", {busy, done, ovf, bcd_out}, 32'd0);
      tick();
    end

    convert("c1234", 14'd1234, 16'h1234, 1'b0, 16'h0000);
    tick();
    chk("pulse_single", done, 1'b0);
    chk("hold_1234", bcd_out, 16'h1234);

    convert("c9999", 14'd9999, 16'h9999, 1'b0, 16'h1234);
    convert("c10000", 14'd10000, 16'h9999, 1'b1, 16'h9999);
    tick();
    chk("ovf_hold", ovf, 1'b1);
    convert("c16383", 14'd16383, 16'h9999, 1'b1, 16'h9999);
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
    convert("c0", 14'd0, 16'hFFF0, 1'b0, 16'h9999);
    convert("c42", 14'd42, 16'hFF42, 1'b0, 16'hFFF0);
    convert("c1005", 14'd1005, 16'h1005, 1'b0, 16'hFF42);
    convert("c12000", 14'd12000, 16'h9999, 1'b1, 16'h1005);
    convert("c908", 14'd908, 16'hF908, 1'b0, 16'h9999);
`else
    convert("c0", 14'd0, 16'h0000, 1'b0, 16'h9999);
    convert("c42", 14'd42, 16'h0042, 1'b0, 16'h0000);
    convert("c1005", 14'd1005, 16'h1005, 1'b0, 16'h0042);
    convert("c908", 14'd908, 16'h0908, 1'b0, 16'h1005);
`endif
    tick();

    // Start with 500, ignored restart at E5, then accepted restart in the done cycle.
    bin_in = 14'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bin_in = 14'd77;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 5;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_first_latency", n, BW);
    chk("b2b_first_bcd", bcd_out, 16'h0500);
    bin_in = 14'd77;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_gap", n, BW + 1);
    chk("b2b_second_bcd", bcd_out, 16'h0077);

    // Reset mid-conversion aborts with no done pulse.
    tick();
    bin_in = 14'd8765;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", {busy, done, ovf, bcd_out}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 16'h0000) bad = 1;
      tick();
    end
    chk("abort_quiet", 32'(bad), 32'd0);
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
    convert("c3", 14'd3, 16'hFFF3, 1'b0, 16'h0000);
`else
    convert("c3", 14'd3, 16'h0003, 1'b0, 16'h0000);
`endif
    tick();
    chk("final_pulse_clear", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter that produces the 4-digit packed BCD word consumed by the on-screen numeral drawer. Uses shift-and-add-3 (double dabble), one bit per clock. The countdown/score logic hands it a binary value with a start pulse. The BCD output register updates atomically on completion, so the drawer never renders a partially converted value mid-frame.

Parameters:
- BIN_W, 14, width of binary input. Max representable display value is 9999. Legal range is 14..16.
- SAT_VAL, 16'h9999, BCD word output when the input exceeds 9999.

Ports:
- clk  input  1  system clock (pixel-domain clock shared with the drawer)
- rst  input  1  reset; synchronous, active-high
- bin_in  input  BIN_W  binary value to convert; sampled only on an accepted start
- start  input  1  request pulse; accepted only when busy=0
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse; bcd_out is new in this cycle
- ovf  output  1  set with done when the sampled input was > 9999; holds until the next done
- bcd_out  output  16  packed BCD {thousands, hundreds, tens, units}; registered and held between conversions

Behaviour:
- Reset values (rst sampled high at a clk edge): state=IDLE, busy=0, done=0, ovf=0, bcd_out=16'h0000, internal shift/count registers=0.
- Reset mid-conversion aborts immediately. No done pulse is issued and bcd_out returns to 0.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1. Iteration counter 0..BIN_W-1.
- IDLE->SHIFT: start=1 at an edge. On that edge bin_in is latched into the binary shift register, the BCD scratch register is cleared, the counter is cleared, and the overflow flag is computed from the latched value (bin_in > 9999).
- SHIFT, each edge:
  - For each scratch nibble >= 5, add 3 to that nibble.
  - Shift {scratch, binary} left by 1, moving the binary MSB into scratch bit 0.
  - Increment the counter.
- SHIFT->IDLE: on the edge performing shift number BIN_W (counter==BIN_W-1).
  - The same edge writes the final adjusted-and-shifted value to bcd_out, or SAT_VAL if overflow.
  - On that edge: done<=1, ovf<=overflow flag, busy<=0.
- Latency: start sampled at edge E0. busy=1 during cycles E0..E(BIN_W). done=1 and new bcd_out are visible in the cycle after edge E(BIN_W), i.e. BIN_W cycles after acceptance (14 at default).
- done is high for exactly one cycle; it is cleared on the next edge unless a new completion occurs.
- start while busy=1 is ignored. No queuing, and bin_in is not resampled.
- start in the same cycle done=1 (state already IDLE) is accepted. Back-to-back conversions therefore run every BIN_W+1 cycles.
- bcd_out changes only on a completion edge or reset; it never shows intermediate scratch values.
- Scratch arithmetic is 16 bits wide. No nibble may exceed 9 after adjust-and-shift for inputs <= 9999.
- Input of 0 yields 16'h0000. Input of 9999 yields 16'h9999 with ovf=0. Input of 10000 (or larger, up to 2^BIN_W-1) yields SAT_VAL with ovf=1.

Optional Feature:
- Macro: BIN_TO_BCD_LEADING_BLANK_EN.
- Defined: at completion, leading zero digits of the final result are replaced with nibble 4'hF, scanning from the thousands digit downward and stopping at the first non-zero digit. The units digit is never blanked. The drawer's default case renders 4'hF as dark.
  - Example: 42 -> 16'hFF42. 0 -> 16'hFFF0.
  - Not applied to SAT_VAL.
- Undefined: leading zeros are output as 4'h0. Example: 42 -> 16'h0042.

Test Plan:
- Reset then idle, start=0 -> bcd_out=16'h0000, busy=0, done=0, ovf=0, held for 20 cycles.
- bin_in=1234, start pulse at edge E0 -> busy=1 for 14 cycles. done=1 for exactly one cycle after edge E14 with bcd_out=16'h1234, ovf=0. bcd_out stays 16'h0000 until then.
- bin_in=9999, then bin_in=10000, then 16383 -> 16'h9999 ovf=0; 16'h9999 ovf=1; 16'h9999 ovf=1.
- Start with 500; pulse start again with 77 at E5, then start with 77 in the done cycle -> first result 16'h0500, the E5 start is ignored, the second result is 16'h0077 BIN_W+1 cycles after the first done.
- Start with 8765, assert rst at E7 -> busy=0, no done pulse, bcd_out=16'h0000. Next start with 3 gives 16'h0003.
- With BIN_TO_BCD_LEADING_BLANK_EN defined: inputs 0, 42, 1005, 12000 -> 16'hFFF0, 16'hFF42, 16'h1005, 16'h9999 ovf=1.
